// File: rtl/des_sbox_compress_seq.sv
// DES S-box compression stage: 48-bit (E(R) xor K) word in, 32-bit word out.
// One shared lookup datapath evaluates SBOX_PER_CYCLE S-boxes per clock,
// then the result is optionally passed through the DES P permutation.
//
// Handshake: a transfer happens on the rising clock edge where valid and
// ready are both high; valid is never withdrawn by the DUT until that edge,
// data is stable while valid is high, and ready/valid depend on state only.
module des_sbox_compress_seq #(
    parameter int SBOX_PER_CYCLE = 1,
    parameter int APPLY_P        = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Only divisors of 8 give a whole number of SUB cycles.
    if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
          SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_spc
        $error("des_sbox_compress_seq: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end

    // ST_LOAD is the first cycle of the DONE phase: it registers the final
    // (optionally permuted) word so out_data never sees a combinational path.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] STEP = 4'(SBOX_PER_CYCLE);

    // Each table holds 64 nibbles indexed by {row, column}; entry 0 is the MSB nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // Output bit i (1-based, MSB first) takes input bit P_TBL[i-1].
    localparam int P_TBL [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                   1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9,
                                  19, 13, 30,  6, 22, 11,  4, 25};

    function automatic logic [3:0] sbox_lookup(input logic [2:0] idx, input logic [5:0] b);
        logic [5:0]   ent;
        logic [255:0] tbl;
        ent = {b[5], b[0], b[4:1]};
        case (idx)
            3'd0:    tbl = S1;
            3'd1:    tbl = S2;
            3'd2:    tbl = S3;
            3'd3:    tbl = S4;
            3'd4:    tbl = S5;
            3'd5:    tbl = S6;
            3'd6:    tbl = S7;
            default: tbl = S8;
        endcase
        return tbl[4*(63 - int'(ent)) +: 4];
    endfunction

    function automatic logic [31:0] p_permute(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 1; i <= 32; i++) begin
            y[32 - i] = x[32 - P_TBL[i-1]];
        end
        return y;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [47:0] cap_q, cap_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] out_q, out_d;

    logic [31:0] acc_lkp;
    logic [2:0]  grp;
    logic        last_grp;

    // Evaluate this cycle's S-box groups and merge them into the accumulator.
    always_comb begin
        acc_lkp = acc_q;
        grp     = '0;
        for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
            grp = cnt_q + 3'(k);
            acc_lkp[4*(7 - int'(grp)) +: 4] = sbox_lookup(grp, cap_q[6*(7 - int'(grp)) +: 6]);
        end
    end

    assign last_grp = (({1'b0, cnt_q} + STEP) == 4'd8);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_d   = in_data;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                acc_d = acc_lkp;
                cnt_d = cnt_q + STEP[2:0];
                if (last_grp) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                out_d   = (APPLY_P != 0) ? p_permute(acc_q) : acc_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_q;
    assign dbg_state = state_q;

endmodule
